cache_mem_arbiter: RTL
======================

# cache_mem_arbiter

Two-to-one arbiter between the L1 instruction cache and the L1 data cache on one side and the system memory bus on the other. Each L1 cache drives its arbiter-side request/response channel into this block. The block grants one cache at a time and forwards its line fill (read) or line writeback (write) to the bus. It then routes the returning response beats back to the granted cache.

## Interface
Parameters:
- WORDSIZE, 64, width of bus address/data beat
- TAGWIDTH, 13, width of request/response tags; bit 12 is the READ flag (1 = read, 0 = write)
- BEATS, 8, data beats per cache line (read response or write data)

Ports (clock and reset first; one clock, reset is synchronous and active-high):
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- {i,d}_reqcyc  in  1  cache request valid, held until acked
- {i,d}_req  in  WORDSIZE  line address (first beat), then write data beats
- {i,d}_reqtag  in  TAGWIDTH  request tag
- {i,d}_reqack  out  1  per-beat request acknowledge
- {i,d}_respcyc  out  1  response beat valid
- {i,d}_resp  out  WORDSIZE  response data beat
- {i,d}_resptag  out  TAGWIDTH  response tag
- {i,d}_respack  in  1  cache accepts response beat
- bus_reqcyc  out  1  bus request valid
- bus_req  out  WORDSIZE  bus address/data beat
- bus_reqtag  out  TAGWIDTH  bus request tag
- bus_reqack  in  1  bus accepts request beat
- bus_respcyc  in  1  bus response beat valid
- bus_resp  in  WORDSIZE  bus response beat
- bus_resptag  in  TAGWIDTH  bus response tag
- bus_respack  out  1  arbiter accepts response beat

## Operation
- One transaction outstanding in total. Registers hold the following:
  - owner: I or D
  - tag_q: the issued tag
  - beat counter: 0..BEATS
  - FSM state
- IDLE:
  - Sample i_reqcyc and d_reqcyc, pick a winner (see Configuration), latch owner and tag_q = owner reqtag.
  - Go to ISSUE.
  - No reqcyc asserted: stay in IDLE.
- ISSUE:
  - bus_reqcyc/bus_req/bus_reqtag are driven combinationally from the owner's request.
  - owner reqack = bus_reqack; the loser's reqack stays 0.
  - On bus_reqack: if tag_q[12] = 1, go to RDWAIT; otherwise go to WDATA. Counter is cleared in both cases.
- WDATA:
  - Same pass-through of owner request and reqack.
  - Each cycle with bus_reqcyc & bus_reqack increments the counter.
  - The beat that makes the counter equal BEATS goes to IDLE.
- RDWAIT:
  - A bus_respcyc with bus_resptag == tag_q is forwarded: owner respcyc = 1, resp = bus_resp, resptag = bus_resptag, and bus_respack = owner respack.
  - Counter increments only on bus_respcyc & bus_respack.
  - The BEATS-th accepted beat goes to IDLE.
- Stray beats: any bus_respcyc outside RDWAIT, or with a tag mismatch, gets bus_respack = 1, is not forwarded, and does not count. The bus never deadlocks.
- The non-owner's respcyc and reqack are always 0.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, counter 0, owner = I.
  - Round-robin pointer favours D first.
- Grant latency: reqcyc seen in IDLE at edge N makes bus_reqcyc high in cycle N+1. The zero-bubble minimum is 1 cycle.
- Back-to-back: the final beat at edge N returns to IDLE. The next grant is evaluated in cycle N+1, so bus_reqcyc is low for at least 1 cycle between transactions.
- Request signals are pass-through, so bus_req changes in the same cycle as the owner's req.
- Response path is combinational (bus to owner, 0-cycle); respack is combinational back to the bus.
- Requester drops reqcyc mid-ISSUE: the FSM holds in ISSUE. This is a protocol violation, flagged by an assertion in simulation.
- Reset asserted mid-transaction: the FSM returns to IDLE on that edge and the transaction is abandoned. Late response beats are then dropped as strays.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requesters assert in IDLE, the grant goes to the side not granted last.
  - The pointer updates on each grant.
- Undefined: fixed priority, D-side always wins ties.
- Single-requester behaviour is identical in both builds.

## Test plan
- Single read: d_req=0x1000, d_reqtag=0x1005 → bus_reqcyc in the next cycle with the same addr/tag. Bus returns 8 beats 0xA0..0xA7 with tag 0x1005 → d_respcyc ×8 with identical data, i_respcyc stays 0, then IDLE.
- Single write: i_reqtag=0x0003, addr 0x2000 + 8 data beats → exactly 9 bus_reqack handshakes forwarded as i_reqack, no response expected, return to IDLE.
- Simultaneous i/d reads, three rounds:
  - with ARB_ROUND_ROBIN_EN: grants D, I, D;
  - without: D, D, D (I served only after D idles).
- Backpressure: d_respack low on beats 3–4 → bus_respack low on the same cycles, no beat lost or duplicated, counter ends at 8.
- Stray/mismatched: bus_respcyc with tag 0x1777 during RDWAIT (tag_q=0x1005) → bus_respack=1, d_respcyc=0, counter unchanged.
- Reset after 4 read beats → all outputs 0 on the next cycle. The remaining 4 beats are acked and dropped; a fresh i_reqcyc is then granted normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one system memory bus between the L1 I-cache and
// the L1 D-cache. Only one transaction is in flight at a time. The request
// beats of the granted cache pass straight through to the bus. Matching read
// response beats are routed straight back to it.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both caches
// request in the same cycle. When it is left undefined, the D-side wins ties.
module cache_mem_arbiter #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned TAGWIDTH = 13,
  parameter int unsigned BEATS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  // Instruction cache side
  input  logic                i_reqcyc,
  input  logic [WORDSIZE-1:0] i_req,
  input  logic [TAGWIDTH-1:0] i_reqtag,
  output logic                i_reqack,
  output logic                i_respcyc,
  output logic [WORDSIZE-1:0] i_resp,
  output logic [TAGWIDTH-1:0] i_resptag,
  input  logic                i_respack,
  // Data cache side
  input  logic                d_reqcyc,
  input  logic [WORDSIZE-1:0] d_req,
  input  logic [TAGWIDTH-1:0] d_reqtag,
  output logic                d_reqack,
  output logic                d_respcyc,
  output logic [WORDSIZE-1:0] d_resp,
  output logic [TAGWIDTH-1:0] d_resptag,
  input  logic                d_respack,
  // System bus side
  output logic                bus_reqcyc,
  output logic [WORDSIZE-1:0] bus_req,
  output logic [TAGWIDTH-1:0] bus_reqtag,
  input  logic                bus_reqack,
  input  logic                bus_respcyc,
  input  logic [WORDSIZE-1:0] bus_resp,
  input  logic [TAGWIDTH-1:0] bus_resptag,
  output logic                bus_respack
);

  localparam int unsigned CntW    = $clog2(BEATS + 1);
  // The tag MSB is the read flag (1 = line fill, 0 = writeback).
  localparam int unsigned ReadBit = TAGWIDTH - 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWdata, StRdwait} state_e;

  state_e              r_state;
  logic                r_own_d;    // 1: D-cache owns the bus, 0: I-cache
  logic [TAGWIDTH-1:0] r_tag;
  logic [CntW-1:0]     r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic                r_last_d;   // last grant went to the D-side
`endif

  logic                w_own_reqcyc;
  logic [WORDSIZE-1:0] w_own_req;
  logic [TAGWIDTH-1:0] w_own_reqtag;
  logic                w_own_respack;
  logic                w_req_phase;
  logic                w_fwd;
  logic                w_grant_d;

  assign w_own_reqcyc  = r_own_d ? d_reqcyc  : i_reqcyc;
  assign w_own_req     = r_own_d ? d_req     : i_req;
  assign w_own_reqtag  = r_own_d ? d_reqtag  : i_reqtag;
  assign w_own_respack = r_own_d ? d_respack : i_respack;
  assign w_req_phase   = (r_state == StIssue) || (r_state == StWdata);
  // Only beats carrying the issued tag, while a fill is pending, go to the owner.
  assign w_fwd         = (r_state == StRdwait) && bus_respcyc && (bus_resptag == r_tag);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_d = d_reqcyc && (!i_reqcyc || !r_last_d);
`else
  assign w_grant_d = d_reqcyc;
`endif

  // Transaction FSM: grant, address beat, write data beats or read response beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_own_d  <= 1'b0;
      r_tag    <= '0;
      r_cnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_reqcyc || d_reqcyc) begin
            r_own_d  <= w_grant_d;
            r_tag    <= w_grant_d ? d_reqtag : i_reqtag;
            r_cnt    <= '0;
            r_state  <= StIssue;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        StIssue: begin
          if (bus_reqcyc && bus_reqack) begin
            r_cnt   <= '0;
            r_state <= r_tag[ReadBit] ? StRdwait : StWdata;
          end
        end
        StWdata: begin
          if (bus_reqcyc && bus_reqack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CntW'(BEATS - 1)) r_state <= StIdle;
          end
        end
        StRdwait: begin
          if (w_fwd && w_own_respack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CntW'(BEATS - 1)) r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Request pass-through to the bus and response routing back to the owner.
  always_comb begin
    bus_reqcyc  = w_req_phase && w_own_reqcyc;
    bus_req     = w_req_phase ? w_own_req    : '0;
    bus_reqtag  = w_req_phase ? w_own_reqtag : '0;
    i_reqack    = w_req_phase && !r_own_d && bus_reqack;
    d_reqack    = w_req_phase &&  r_own_d && bus_reqack;
    i_respcyc   = w_fwd && !r_own_d;
    d_respcyc   = w_fwd &&  r_own_d;
    i_resp      = i_respcyc ? bus_resp    : '0;
    i_resptag   = i_respcyc ? bus_resptag : '0;
    d_resp      = d_respcyc ? bus_resp    : '0;
    d_resptag   = d_respcyc ? bus_resptag : '0;
    // Stray beats are swallowed so the bus can never stall on them.
    bus_respack = w_fwd ? w_own_respack : bus_respcyc;
  end

  // A granted cache must keep its request up until the address beat is acked.
  a_hold_reqcyc: assert property (@(posedge clk) disable iff (reset)
    (r_state == StIssue) |-> w_own_reqcyc);

endmodule
